markov_predictor: RTL and testbench



---
 rtl/markov_predictor.sv | 146 ++++++++++++++
 tb/tb_markov_predictor.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/markov_predictor.sv
// First-order Markov opponent model for RPS: counts user move transitions and emits the counter move.
// Optional row-halving decay on counter overflow is enabled by defining MARKOV_DECAY_EN.
module markov_predictor #(
  parameter int CNT_W = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] user,
  output logic [1:0] choice,
  output logic [1:0] pred,
  output logic       ready
);

  typedef enum logic [2:0] {IDLE, UPDATE, SCAN0, SCAN1, SCAN2, EMIT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [3][3];
  logic [CNT_W-1:0] cnt_d [3][3];
  logic             have_prev_q, have_prev_d;
  logic [1:0]       prev_q, prev_d;
  logic [1:0]       cur_q, cur_d;
  logic [1:0]       best_idx_q, best_idx_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
  logic [1:0]       choice_q, choice_d;
  logic [1:0]       pred_q, pred_d;
  logic             ready_q, ready_d;
  logic [1:0]       emit_pred;

  function automatic logic [1:0] beat(input logic [1:0] mv);
    case (mv)
      2'b00:   beat = 2'b10;
      2'b01:   beat = 2'b00;
      2'b10:   beat = 2'b01;
      default: beat = 2'b00;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    have_prev_d = have_prev_q;
    prev_d      = prev_q;
    cur_d       = cur_q;
    best_idx_d  = best_idx_q;
    best_cnt_d  = best_cnt_q;
    choice_d    = choice_q;
    pred_d      = pred_q;
    ready_d     = ready_q;
    emit_pred   = pred_q;

    case (state_q)
      IDLE: begin
        if (start && user != 2'b11) begin
          cur_d   = user;
          ready_d = 1'b0;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        if (have_prev_q) begin
          if (cnt_q[prev_q][cur_q] != CNT_MAX) begin
            cnt_d[prev_q][cur_q] = cnt_q[prev_q][cur_q] + 1'b1;
          end
`ifdef MARKOV_DECAY_EN
          else begin
            // Age the whole row so relative preferences survive the overflow.
            for (int k = 0; k < 3; k++) begin
              cnt_d[prev_q][k] = cnt_q[prev_q][k] >> 1;
            end
            cnt_d[prev_q][cur_q] = (CNT_MAX >> 1) + 1'b1;
          end
`endif
        end
        prev_d      = cur_q;
        have_prev_d = 1'b1;
        state_d     = SCAN0;
      end
      SCAN0: begin
        best_cnt_d = cnt_q[cur_q][0];
        best_idx_d = 2'd0;
        state_d    = SCAN1;
      end
      SCAN1: begin
        if (cnt_q[cur_q][1] > best_cnt_q) begin
          best_cnt_d = cnt_q[cur_q][1];
          best_idx_d = 2'd1;
        end
        state_d = SCAN2;
      end
      SCAN2: begin
        if (cnt_q[cur_q][2] > best_cnt_q) begin
          best_cnt_d = cnt_q[cur_q][2];
          best_idx_d = 2'd2;
        end
        state_d = EMIT;
      end
      EMIT: begin
        // An empty row means no history after this move: guess the user repeats it.
        emit_pred = (best_cnt_q == '0) ? cur_q : best_idx_q;
        pred_d    = emit_pred;
        choice_d  = beat(emit_pred);
        ready_d   = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          cnt_q[i][j] <= '0;
        end
      end
      have_prev_q <= 1'b0;
      prev_q      <= 2'b00;
      cur_q       <= 2'b00;
      best_idx_q  <= 2'b00;
      best_cnt_q  <= '0;
      choice_q    <= 2'b00;
      pred_q      <= 2'b00;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      have_prev_q <= have_prev_d;
      prev_q      <= prev_d;
      cur_q       <= cur_d;
      best_idx_q  <= best_idx_d;
      best_cnt_q  <= best_cnt_d;
      choice_q    <= choice_d;
      pred_q      <= pred_d;
      ready_q     <= ready_d;
    end
  end

  assign choice = choice_q;
  assign pred   = pred_q;
  assign ready  = ready_q;

endmodule

// File: tb/tb_markov_predictor.sv
// Self-checking bench for markov_predictor: a round-level behavioural model is compared every cycle,
// plus directed rounds with hand-computed predictions. Honours MARKOV_DECAY_EN in the model.
module tb_markov_predictor;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [1:0] user  = 2'b00;
  logic [1:0] choice;
  logic [1:0] pred;
  logic       ready;

  markov_predictor #(.CNT_W(CNT_W)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .user   (user),
    .choice (choice),
    .pred   (pred),
    .ready  (ready)
  );

  always #5 clock = ~clock;

  int vecCount = 0;
  int errCount = 0;
  bit checkEn  = 1'b0;

  // Behavioural model: whole round resolved at once, outputs released five cycles later.
  int         mCnt [3][3];
  bit         mHavePrev;
  int         mPrev;
  int         mBusy;
  int         mPending;
  logic       expReady;
  logic [1:0] expChoice;
  logic [1:0] expPred;

  function automatic logic [1:0] beatOf(input int mv);
    case (mv)
      0:       return 2'b10;
      1:       return 2'b00;
      2:       return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        mCnt[i][j] = 0;
    mHavePrev = 1'b0;
    mPrev     = 0;
    mBusy     = 0;
    mPending  = 0;
    expReady  = 1'b1;
    expChoice = 2'b00;
    expPred   = 2'b00;
  endtask

  task automatic modelRound(input int u);
    int maxVal;
    if (mHavePrev) begin
      if (mCnt[mPrev][u] < CNT_MAX) begin
        mCnt[mPrev][u] = mCnt[mPrev][u] + 1;
      end else begin
`ifdef MARKOV_DECAY_EN
        for (int k = 0; k < 3; k++) mCnt[mPrev][k] = mCnt[mPrev][k] / 2;
        mCnt[mPrev][u] = mCnt[mPrev][u] + 1;
`endif
      end
    end
    mPrev     = u;
    mHavePrev = 1'b1;
    maxVal = 0;
    for (int k = 0; k < 3; k++) if (mCnt[u][k] > maxVal) maxVal = mCnt[u][k];
    mPending = u;
    if (maxVal != 0) begin
      for (int k = 2; k >= 0; k--) if (mCnt[u][k] == maxVal) mPending = k;
    end
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      modelReset();
    end else if (mBusy > 0) begin
      mBusy = mBusy - 1;
      if (mBusy == 0) begin
        expReady  = 1'b1;
        expPred   = 2'(mPending);
        expChoice = beatOf(mPending);
      end
    end else if (start && user != 2'b11) begin
      modelRound(int'(user));
      mBusy    = 5;
      expReady = 1'b0;
    end
  end

  always @(negedge clock) begin
    if (checkEn) begin
      vecCount++;
      if (ready !== expReady || choice !== expChoice || pred !== expPred) begin
        errCount++;
        $display("[TB] FAIL cycle t=%0t: got ready=%b choice=%b pred=%b, want ready=%b choice=%b pred=%b",
                 $time, ready, choice, pred, expReady, expChoice, expPred);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [1:0] wantPred, input logic [1:0] wantChoice);
    vecCount++;
    if (pred !== wantPred || choice !== wantChoice || ready !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL %s: got pred=%b choice=%b ready=%b, want pred=%b choice=%b ready=1",
               name, pred, choice, ready, wantPred, wantChoice);
    end
  endtask

  task automatic checkModelCount(input string name, input int got, input int want);
    vecCount++;
    if (got != want) begin
      errCount++;
      $display("[TB] FAIL %s: model count %0d, want %0d", name, got, want);
    end
  endtask

  task automatic waitReady();
    int n = 0;
    while (ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (ready !== 1'b1) begin
      vecCount++;
      errCount++;
      $display("[TB] FAIL waitReady: ready=%b after %0d cycles, want 1", ready, n);
    end
  endtask

  task automatic doReset();
    @(negedge clock);
    #2 reset = 1'b1;
    start = 1'b0;
    @(negedge clock);
    #2 reset = 1'b0;
    checkEn = 1'b1;
  endtask

  // One round; optionally a second start pulse lands while the DUT is busy.
  task automatic applyStimulus(input logic [1:0] mv, input bit busyPulse);
    waitReady();
    @(posedge clock);
    #2 start = 1'b1;
    user = mv;
    @(posedge clock);
    #2 start = 1'b0;
    if (busyPulse) begin
      @(posedge clock);
      #2 start = 1'b1;
      user = 2'b10;
      @(posedge clock);
      #2 start = 1'b0;
    end
    @(negedge clock);
    waitReady();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    doReset();

    applyStimulus(2'b00, 1'b0);
    checkOutput("firstRock", 2'b00, 2'b10);

    // Abort a scissor round in SCAN1 with an asynchronous reset.
    @(posedge clock);
    #2 start = 1'b1;
    user = 2'b01;
    @(posedge clock);
    #2 start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #3 reset = 1'b1;
    #1 checkOutput("asyncReset", 2'b00, 2'b00);
    @(negedge clock);
    #2 reset = 1'b0;
    applyStimulus(2'b01, 1'b0);
    checkOutput("afterAbort", 2'b01, 2'b00);

    doReset();
    applyStimulus(2'b00, 1'b0);
    applyStimulus(2'b01, 1'b0);
    applyStimulus(2'b00, 1'b0);
    applyStimulus(2'b01, 1'b0);
    checkOutput("rsrsRound4", 2'b00, 2'b10);
    checkModelCount("rsrsCntSR", mCnt[1][0], 1);
    checkModelCount("rsrsCntRS", mCnt[0][1], 2);
    applyStimulus(2'b00, 1'b0);
    checkOutput("rsrsRound5", 2'b01, 2'b00);

    doReset();
    for (int r = 1; r <= 6; r++) begin
      applyStimulus(2'b00, 1'b0);
      checkOutput($sformatf("rockRound%0d", r), 2'b00, 2'b10);
`ifdef MARKOV_DECAY_EN
      if (r == 5) checkModelCount("rockCntR5", mCnt[0][0], 2);
`else
      if (r == 5) checkModelCount("rockCntR5", mCnt[0][0], 3);
`endif
    end
    checkModelCount("rockCntR6", mCnt[0][0], 3);
    applyStimulus(2'b01, 1'b0);
    checkOutput("satTail1", 2'b01, 2'b00);
    applyStimulus(2'b00, 1'b0);
    applyStimulus(2'b01, 1'b0);
    applyStimulus(2'b00, 1'b0);
    checkOutput("satTail4", 2'b00, 2'b10);

    doReset();
    applyStimulus(2'b10, 1'b0);
    checkOutput("firstPaper", 2'b10, 2'b01);
    applyStimulus(2'b00, 1'b1);
    checkOutput("busyPulse", 2'b00, 2'b10);
    @(posedge clock);
    #2 start = 1'b1;
    user = 2'b11;
    @(posedge clock);
    #2 start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checkOutput("invalidMove", 2'b00, 2'b10);
    applyStimulus(2'b00, 1'b0);
    checkOutput("afterIgnored", 2'b00, 2'b10);
    checkModelCount("ignoredCntRP", mCnt[0][2], 0);

    doReset();
    applyStimulus(2'b10, 1'b0);
    applyStimulus(2'b00, 1'b0);
    applyStimulus(2'b10, 1'b0);
    applyStimulus(2'b01, 1'b0);
    applyStimulus(2'b10, 1'b0);
    checkOutput("tieLowest", 2'b00, 2'b10);
    checkModelCount("tieCntPR", mCnt[2][0], 1);
    checkModelCount("tieCntPS", mCnt[2][1], 1);

    @(negedge clock);
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
